uart_program_loader: RTL and testbench

- Upstream feeder for the 8-bit CPU's 16-byte RAM. Receives a program over usb_rx (8N1 UART) and emits one write strobe per byte to the RAM programming port.
- Holds the CPU off the bus while loading. Runs on the 100 MHz board clock, not bus_clk.
- Contains a UART receiver sub-module and a framing FSM: sync byte, then RAM_DEPTH data bytes.

---
 rtl/uart_program_loader_pkg.sv | 24 ++
 rtl/uart_program_loader_uart_rx.sv | 103 ++++++++++
 rtl/uart_program_loader.sv | 181 ++++++++++++++++++
 tb/tb_uart_program_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// rtl/uart_program_loader_pkg.sv - shared types, constants and helpers for the UART program loader
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_CHECK    = 2'd2,
    ST_HOLD_ERR = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// rtl/uart_program_loader_uart_rx.sv - 8N1 UART receiver with input synchroniser
// Emits one-cycle byte_valid on a good stop bit, one-cycle frame_err otherwise.
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF  = CPB / 2;
  localparam int          CNT_W = $clog2(CPB + 1);

  logic            sync1_q, sync2_q;
  rx_state_e       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Mid-start re-sample rejects glitches shorter than half a bit.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART program loader: sync byte then RAM_DEPTH bytes into CPU RAM
// Optional trailing checksum byte enabled by UART_LOADER_CHECKSUM_EN.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned RAM_DEPTH    = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic              prog_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * clks_per_bit(CLK_HZ, BAUD);
  localparam int          GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam int          CNT_W     = ADDR_W + 1;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  addr_cnt_q, addr_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [7:0]        prog_data_q, prog_data_d;
  logic              prog_we_q, prog_we_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              sum_ok;
  assign sum_ok = (8'(sum_q + rx_data) == 8'h00);
`endif

  logic             is_sync;
  logic             gap_expired;
  logic [CNT_W-1:0] addr_next;
  logic             image_full;

  assign is_sync     = rx_valid && (rx_data == SYNC_BYTE);
  assign gap_expired = (gap_q == GAP_W'(GAP_LIMIT - 1));
  assign addr_next   = addr_cnt_q + 1'b1;
  assign image_full  = (addr_next == CNT_W'(RAM_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= '0;
      gap_q       <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_we_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      gap_q       <= gap_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_we_q   <= prog_we_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // A sync byte is ordinary data once inside LOAD; only IDLE and HOLD_ERR treat it as a restart.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    gap_d      = gap_q;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD_ERR: begin
        if (is_sync) begin
          state_d    = ST_LOAD;
          addr_cnt_d = '0;
          gap_d      = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          gap_d      = '0;
          addr_cnt_d = addr_next;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
          if (image_full) state_d = ST_CHECK;
`else
          if (image_full) state_d = ST_IDLE;
`endif
        end else if (rx_ferr || gap_expired) begin
          state_d = ST_HOLD_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) begin
          state_d = sum_ok ? ST_IDLE : ST_HOLD_ERR;
        end else if (rx_ferr || gap_expired) begin
          state_d = ST_HOLD_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // cpu_hold covers both the current and next state so it falls one cycle after load_done.
  always_comb begin
    prog_we_d   = 1'b0;
    load_done_d = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    load_err_d  = load_err_q;
    cpu_hold_d  = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    if (state_q == ST_LOAD && rx_valid) begin
      prog_we_d   = 1'b1;
      prog_addr_d = addr_cnt_q[ADDR_W-1:0];
      prog_data_d = rx_data;
`ifndef UART_LOADER_CHECKSUM_EN
      load_done_d = image_full;
`endif
    end
`ifdef UART_LOADER_CHECKSUM_EN
    if (state_q == ST_CHECK && state_d == ST_IDLE) load_done_d = 1'b1;
`endif
    if (state_q != ST_HOLD_ERR && state_d == ST_HOLD_ERR) load_err_d = 1'b1;
    if (state_q != ST_LOAD && state_d == ST_LOAD) load_err_d = 1'b0;
  end

  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign prog_we   = prog_we_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - randomized self-checking bench with a byte-level loader model
module tb_uart_program_loader;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int          CPB    = 10;
  localparam int unsigned TO_BITS = 40;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_ERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_we, cpu_hold, load_done, load_err, busy;

  uart_program_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(4), .RAM_DEPTH(16),
    .SYNC_BYTE(SYNC), .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_we(prog_we), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_write;
    logic [3:0] addr;
    logic [7:0] data;
    bit         done;
  } exp_t;

  exp_t       expq[$];
  int         total = 0, bad = 0;
  int         mstate = M_IDLE, maddr = 0, msum = 0;
  bit         merr = 0;
  int         n_writes = 0, n_dones = 0, cyc = 0, last_we_cyc = 0, err_rise_cyc = 0;
  logic [7:0] img[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ferr);
    exp_t e;
    if (ferr) begin
      if (mstate == M_LOAD || mstate == M_CHECK) begin
        mstate = M_ERR;
        merr   = 1;
      end
      return;
    end
    case (mstate)
      M_LOAD: begin
        e.is_write = 1;
        e.addr     = 4'(maddr);
        e.data     = b;
`ifdef UART_LOADER_CHECKSUM_EN
        e.done     = 0;
`else
        e.done     = (maddr == 15);
`endif
        expq.push_back(e);
        msum  = (msum + b) % 256;
        maddr = maddr + 1;
`ifdef UART_LOADER_CHECKSUM_EN
        if (maddr == 16) mstate = M_CHECK;
`else
        if (maddr == 16) mstate = M_IDLE;
`endif
      end
      M_CHECK: begin
        if ((msum + b) % 256 == 0) begin
          e.is_write = 0;
          e.addr     = 0;
          e.data     = 0;
          e.done     = 1;
          expq.push_back(e);
          mstate = M_IDLE;
        end else begin
          mstate = M_ERR;
          merr   = 1;
        end
      end
      default: begin
        if (b == SYNC) begin
          mstate = M_LOAD;
          maddr  = 0;
          msum   = 0;
          merr   = 0;
        end
      end
    endcase
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    model_byte(b, !stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_ok;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    send_frame(b, ok);
    wait_cycles(4 + (ok ? 0 : 16) + g);
    check("cpu_hold_after_byte", cpu_hold, (mstate != M_IDLE));
    check("busy_after_byte", busy, (mstate != M_IDLE));
    check("load_err_after_byte", load_err, merr);
    check("writes_pending", expq.size(), 0);
  endtask

  task automatic send_image(input int max_gap);
    int s;
    s = 0;
    send_byte(SYNC, 1, max_gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], 1, max_gap);
      s = s + img[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'((256 - (s % 256)) % 256), 1, max_gap);
`endif
  endtask

  task automatic compare_loop();
    logic [3:0] la;
    logic [7:0] ld;
    bit         prev_done, prev_err;
    exp_t       e;
    la = '0; ld = '0; prev_done = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        la = '0; ld = '0; prev_done = 0; prev_err = 0;
        continue;
      end
      if (prev_done) check("hold_cycle_after_done", cpu_hold, 1'b0);
      if (load_err && !prev_err) err_rise_cyc = cyc;
      if (prog_we || load_done) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_strobe: we=%0b done=%0b addr=%0h data=%0h, none expected",
                   prog_we, load_done, prog_addr, prog_data);
        end else begin
          e = expq.pop_front();
          check("strobe_kind", prog_we, e.is_write);
          check("done_flag", load_done, e.done);
          check("hold_during_strobe", cpu_hold, 1'b1);
          if (e.is_write) begin
            check("prog_addr", prog_addr, e.addr);
            check("prog_data", prog_data, e.data);
            n_writes++;
            last_we_cyc = cyc;
          end
          if (load_done) n_dones++;
        end
        la = prog_addr;
        ld = prog_data;
      end else begin
        check("addr_data_hold", {prog_addr, prog_data}, {la, ld});
      end
      prev_done = load_done;
      prev_err  = load_err;
    end
  endtask

  initial begin
    int w0, d0, lat;
    fork
      compare_loop();
    join_none

    wait_cycles(3);
    check("reset_outputs", {prog_we, load_done, load_err, cpu_hold, busy, prog_addr, prog_data}, 0);
    rst = 1'b0;
    wait_cycles(5);

    // happy load 00..0F
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    w0 = n_writes; d0 = n_dones;
    send_image(0);
    check("happy_write_count", n_writes - w0, 16);
    check("happy_done_count", n_dones - d0, 1);
    check("happy_last_addr", prog_addr, 4'hF);
    check("happy_last_data", prog_data, 8'h0F);
    check("happy_hold_released", cpu_hold, 1'b0);

    // preamble noise, including a bad frame while idle
    send_byte(8'h3C, 1, 0);
    send_byte(8'hFF, 1, 0);
    send_byte(8'h5A, 0, 0);
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    w0 = n_writes; d0 = n_dones;
    send_image(30);
    check("noise_write_count", n_writes - w0, 16);
    check("noise_done_count", n_dones - d0, 1);

    // framing error after 5 data bytes
    w0 = n_writes;
    send_byte(SYNC, 1, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1, 10);
    send_byte(8'($urandom), 0, 0);
    check("ferr_write_count", n_writes - w0, 5);
    check("ferr_load_err", load_err, 1'b1);
    check("ferr_cpu_hold", cpu_hold, 1'b1);
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    d0 = n_dones;
    send_image(20);
    check("recover_load_err", load_err, 1'b0);
    check("recover_done_count", n_dones - d0, 1);

    // inter-byte timeout
    send_byte(SYNC, 1, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 0);
    wait_cycles(500);
    if (mstate == M_LOAD || mstate == M_CHECK) begin
      mstate = M_ERR;
      merr   = 1;
    end
    check("timeout_load_err", load_err, 1'b1);
    check("timeout_cpu_hold", cpu_hold, 1'b1);
    lat = err_rise_cyc - last_we_cyc;
    total++;
    if (lat < 399 || lat > 401) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles expected 400", lat);
    end

    // glitch mid-load, then reset after 8 bytes
    w0 = n_writes;
    send_byte(SYNC, 1, 0);
    send_byte(8'($urandom), 1, 0);
    send_byte(8'($urandom), 1, 0);
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(25);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1, 5);
    check("glitch_write_count", n_writes - w0, 8);
    #3 rst = 1'b1;
    #1 check("midload_reset_outputs",
             {prog_we, load_done, load_err, cpu_hold, busy, prog_addr, prog_data}, 0);
    mstate = M_IDLE; maddr = 0; msum = 0; merr = 0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);

    // randomized full loads
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      d0 = n_dones;
      send_byte(8'($urandom_range(8'hA4, 0)), 1, 10);
      send_image(40);
      check("random_done_count", n_dones - d0, 1);
    end

`ifdef UART_LOADER_CHECKSUM_EN
    // checksum accept and reject
    d0 = n_dones;
    send_byte(SYNC, 1, 0);
    for (int i = 0; i < 16; i++) send_byte(8'h01, 1, 0);
    send_byte(8'hF0, 1, 0);
    check("cksum_good_done", n_dones - d0, 1);
    check("cksum_good_err", load_err, 1'b0);
    send_byte(SYNC, 1, 0);
    for (int i = 0; i < 16; i++) send_byte(8'h01, 1, 0);
    send_byte(8'hF1, 1, 0);
    check("cksum_bad_done", n_dones - d0, 1);
    check("cksum_bad_err", load_err, 1'b1);
    check("cksum_bad_hold", cpu_hold, 1'b1);
`endif

    wait_cycles(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
